// File: rtl/ysyx_220053_mem_arb.sv
// Shared memory-port arbiter: LS has priority over IF, with a streak limit so IF
// cannot starve, and a response timeout. One transaction is outstanding at a time.
module ysyx_220053_mem_arb #(
  parameter int ADDR_W    = 64,
  parameter int DATA_W    = 64,
  parameter int LS_STREAK = 4,
  parameter int TIMEOUT   = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req_valid,
  output logic                if_req_ready,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_resp_valid,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_resp_err,
  input  logic                ls_req_valid,
  output logic                ls_req_ready,
  input  logic [ADDR_W-1:0]   ls_addr,
  input  logic                ls_wen,
  input  logic [DATA_W-1:0]   ls_wdata,
  input  logic [DATA_W/8-1:0] ls_wmask,
  output logic                ls_resp_valid,
  output logic [DATA_W-1:0]   ls_rdata,
  output logic                ls_resp_err,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_wen,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic                mem_resp_valid,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                busy,
  output logic                owner
);

  localparam int MASK_W = DATA_W / 8;
  localparam int STRK_W = $clog2(LS_STREAK + 1);
  localparam int TMO_W  = $clog2(TIMEOUT + 1);
  localparam logic [STRK_W-1:0] STRK_MAX = STRK_W'(LS_STREAK);
  localparam logic [TMO_W-1:0]  TMO_MAX  = TMO_W'(TIMEOUT);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]        state_q, state_d;
  logic              owner_q, owner_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              wen_q, wen_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [MASK_W-1:0] wmask_q, wmask_d;
  logic [STRK_W-1:0] streak_q, streak_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              if_rv_q, if_rv_d, ls_rv_q, ls_rv_d;
  logic              if_err_q, if_err_d, ls_err_q, ls_err_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d, ls_rdata_q, ls_rdata_d;

  logic idle_s, ls_win_s, if_win_s;

  // Readies are gated by reset so every output reads 0 while rst is low.
  assign idle_s   = (state_q == S_IDLE) & rst;
  assign ls_win_s = idle_s & ls_req_valid & (~if_req_valid | (streak_q != STRK_MAX));
  assign if_win_s = idle_s & if_req_valid & ~ls_win_s;

  assign if_req_ready  = if_win_s;
  assign ls_req_ready  = ls_win_s;
  assign mem_req_valid = (state_q == S_REQ);
  assign busy          = (state_q != S_IDLE);
  assign owner         = owner_q;
  assign mem_addr      = addr_q;
  assign mem_wen       = wen_q;
  assign mem_wdata     = wdata_q;
  assign mem_wmask     = wmask_q;
  assign if_resp_valid = if_rv_q;
  assign if_resp_err   = if_err_q;
  assign if_rdata      = if_rdata_q;
  assign ls_resp_valid = ls_rv_q;
  assign ls_resp_err   = ls_err_q;
  assign ls_rdata      = ls_rdata_q;

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    addr_d     = addr_q;
    wen_d      = wen_q;
    wdata_d    = wdata_q;
    wmask_d    = wmask_q;
    streak_d   = streak_q;
    tmo_d      = tmo_q;
    if_rv_d    = 1'b0;
    ls_rv_d    = 1'b0;
    if_err_d   = 1'b0;
    ls_err_d   = 1'b0;
    if_rdata_d = if_rdata_q;
    ls_rdata_d = ls_rdata_q;
    case (state_q)
      S_IDLE: begin
        if (ls_win_s) begin
          state_d = S_REQ;
          owner_d = 1'b1;
          addr_d  = ls_addr;
          wen_d   = ls_wen;
          wdata_d = ls_wdata;
          wmask_d = ls_wmask;
          // The streak only grows while IF is actually being held off.
          if (if_req_valid) begin
            streak_d = (streak_q == STRK_MAX) ? streak_q : streak_q + STRK_W'(1);
          end else begin
            streak_d = {STRK_W{1'b0}};
          end
        end else if (if_win_s) begin
          state_d  = S_REQ;
          owner_d  = 1'b0;
          addr_d   = if_addr;
          wen_d    = 1'b0;
          wdata_d  = {DATA_W{1'b0}};
          wmask_d  = {MASK_W{1'b0}};
          streak_d = {STRK_W{1'b0}};
        end else begin
          state_d = S_IDLE;
        end
      end
      S_REQ: begin
        if (mem_req_ready) begin
          state_d = S_RESP;
          tmo_d   = {TMO_W{1'b0}};
        end else begin
          state_d = S_REQ;
        end
      end
      S_RESP: begin
        if (mem_resp_valid) begin
          state_d = S_IDLE;
          if (owner_q) begin
            ls_rv_d    = 1'b1;
            ls_rdata_d = mem_rdata;
          end else begin
            if_rv_d    = 1'b1;
            if_rdata_d = mem_rdata;
          end
        end else if (tmo_q == TMO_MAX) begin
          state_d = S_IDLE;
          if (owner_q) begin
            ls_rv_d    = 1'b1;
            ls_err_d   = 1'b1;
            ls_rdata_d = {DATA_W{1'b0}};
          end else begin
            if_rv_d    = 1'b1;
            if_err_d   = 1'b1;
            if_rdata_d = {DATA_W{1'b0}};
          end
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      owner_q    <= 1'b0;
      addr_q     <= {ADDR_W{1'b0}};
      wen_q      <= 1'b0;
      wdata_q    <= {DATA_W{1'b0}};
      wmask_q    <= {MASK_W{1'b0}};
      streak_q   <= {STRK_W{1'b0}};
      tmo_q      <= {TMO_W{1'b0}};
      if_rv_q    <= 1'b0;
      ls_rv_q    <= 1'b0;
      if_err_q   <= 1'b0;
      ls_err_q   <= 1'b0;
      if_rdata_q <= {DATA_W{1'b0}};
      ls_rdata_q <= {DATA_W{1'b0}};
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      addr_q     <= addr_d;
      wen_q      <= wen_d;
      wdata_q    <= wdata_d;
      wmask_q    <= wmask_d;
      streak_q   <= streak_d;
      tmo_q      <= tmo_d;
      if_rv_q    <= if_rv_d;
      ls_rv_q    <= ls_rv_d;
      if_err_q   <= if_err_d;
      ls_err_q   <= ls_err_d;
      if_rdata_q <= if_rdata_d;
      ls_rdata_q <= ls_rdata_d;
    end
  end

endmodule

// File: tb/tb_ysyx_220053_mem_arb.sv
// Scoreboard bench for ysyx_220053_mem_arb: a bench-side arbitration model and a
// configurable memory responder predict every grant, latched field and response.
module tb_ysyx_220053_mem_arb;

  logic        clk, rst;
  logic        if_req_valid, if_req_ready, if_resp_valid, if_resp_err;
  logic [63:0] if_addr, if_rdata;
  logic        ls_req_valid, ls_req_ready, ls_wen, ls_resp_valid, ls_resp_err;
  logic [63:0] ls_addr, ls_wdata, ls_rdata;
  logic [7:0]  ls_wmask, mem_wmask;
  logic        mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid, busy, owner;
  logic [63:0] mem_addr, mem_wdata, mem_rdata;

  ysyx_220053_mem_arb dut (
    .clk(clk), .rst(rst),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
    .if_resp_valid(if_resp_valid), .if_rdata(if_rdata), .if_resp_err(if_resp_err),
    .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready), .ls_addr(ls_addr),
    .ls_wen(ls_wen), .ls_wdata(ls_wdata), .ls_wmask(ls_wmask),
    .ls_resp_valid(ls_resp_valid), .ls_rdata(ls_rdata), .ls_resp_err(ls_resp_err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata),
    .busy(busy), .owner(owner)
  );

  typedef struct {
    logic        own;
    logic        err;
    logic [63:0] rdata;
    int          cyc;
  } exp_t;

  exp_t sb_q[$];
  logic grant_log[$];
  int   grant_cyc[$];

  int n_checks = 0, n_errors = 0;
  int cyc = 0, if_acc = 0, ls_acc = 0;
  int outstanding = 0, m_streak = 0;
  logic [63:0] m_if_rdata = 64'd0, m_ls_rdata = 64'd0;
  logic [63:0] exp_addr = 64'd0, exp_wdata = 64'd0;
  logic        exp_wen = 1'b0;
  logic [7:0]  exp_wmask = 8'd0;
  int req_wait = 0, resp_wait = 0, stray_cyc = -1;
  logic no_resp = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] mem_f(input logic [63:0] a);
    if (a == 64'h0000_0000_8000_0000) return 64'h0000_0000_0000_0013;
    return a ^ 64'h5A5A_0000_1234_5678;
  endfunction

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Memory responder: stalls request acceptance and responses as configured.
  initial begin
    int rq_cnt, rs_cnt;
    logic pending;
    logic [63:0] lat_addr;
    rq_cnt = 0; rs_cnt = 0; pending = 1'b0; lat_addr = 64'd0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_rdata = 64'd0;
    forever begin
      @(posedge clk); #1;
      mem_req_ready = 1'b0;
      mem_resp_valid = 1'b0;
      if (!rst) begin
        pending = 1'b0;
        rq_cnt = 0;
      end else if (cyc == stray_cyc) begin
        mem_resp_valid = 1'b1;
        mem_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
      end else if (mem_req_valid) begin
        check_eq("mem_addr", mem_addr, exp_addr);
        check_eq("mem_wen", {63'd0, mem_wen}, {63'd0, exp_wen});
        check_eq("mem_wdata", mem_wdata, exp_wdata);
        check_eq("mem_wmask", {56'd0, mem_wmask}, {56'd0, exp_wmask});
        if (rq_cnt >= req_wait) begin
          mem_req_ready = 1'b1;
          pending = 1'b1;
          lat_addr = mem_addr;
          rq_cnt = 0;
          rs_cnt = 0;
        end else begin
          rq_cnt++;
        end
      end else if (pending && !busy) begin
        pending = 1'b0;
      end else if (pending && !no_resp) begin
        if (rs_cnt >= resp_wait) begin
          mem_resp_valid = 1'b1;
          mem_rdata = mem_f(lat_addr);
          pending = 1'b0;
        end else begin
          rs_cnt++;
        end
      end
    end
  end

  // Monitor: checks responses against the scoreboard, then busy/ready, then logs grants.
  initial forever begin
    exp_t e;
    logic exp_ls, exp_if;
    @(negedge clk);
    if (!rst) begin
      sb_q.delete();
      outstanding = 0;
      m_streak = 0;
      m_if_rdata = 64'd0;
      m_ls_rdata = 64'd0;
    end else begin
      if (if_resp_valid || ls_resp_valid) begin
        check_eq("resp_exclusive", {63'd0, if_resp_valid & ls_resp_valid}, 64'd0);
        check_eq("resp_expected", {63'd0, sb_q.size() > 0}, 64'd1);
        if (sb_q.size() > 0) begin
          e = sb_q.pop_front();
          check_eq("resp_owner", {63'd0, ls_resp_valid}, {63'd0, e.own});
          check_eq("resp_err", {63'd0, e.own ? ls_resp_err : if_resp_err}, {63'd0, e.err});
          check_eq("resp_cycle", 64'(cyc), 64'(e.cyc));
          if (e.own) m_ls_rdata = e.rdata;
          else       m_if_rdata = e.rdata;
          outstanding = 0;
        end
      end
      check_eq("if_rdata", if_rdata, m_if_rdata);
      check_eq("ls_rdata", ls_rdata, m_ls_rdata);
      check_eq("busy", {63'd0, busy}, 64'(outstanding));
      exp_ls = (outstanding == 0) && ls_req_valid && (!if_req_valid || m_streak != 4);
      exp_if = (outstanding == 0) && if_req_valid && !exp_ls;
      check_eq("ready", {62'd0, if_req_ready, ls_req_ready}, {62'd0, exp_if, exp_ls});
      if ((ls_req_valid && ls_req_ready) || (if_req_valid && if_req_ready)) begin
        e.own = ls_req_valid && ls_req_ready;
        e.err = no_resp;
        e.cyc = cyc + 3 + req_wait + (no_resp ? 255 : resp_wait);
        if (e.own) begin
          exp_addr = ls_addr; exp_wen = ls_wen; exp_wdata = ls_wdata; exp_wmask = ls_wmask;
          m_streak = if_req_valid ? ((m_streak == 4) ? 4 : m_streak + 1) : 0;
          ls_acc++;
        end else begin
          exp_addr = if_addr; exp_wen = 1'b0; exp_wdata = 64'd0; exp_wmask = 8'd0;
          m_streak = 0;
          if_acc++;
        end
        e.rdata = no_resp ? 64'd0 : mem_f(exp_addr);
        sb_q.push_back(e);
        grant_log.push_back(e.own);
        grant_cyc.push_back(cyc);
        outstanding = 1;
      end
    end
  end

  task automatic wait_idle();
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      if (outstanding == 0 && sb_q.size() == 0) break;
    end
    check_eq("drain", {63'd0, outstanding == 0 && sb_q.size() == 0}, 64'd1);
  endtask

  task automatic if_read(input logic [63:0] a);
    int start;
    start = if_acc;
    if_addr = a;
    if_req_valid = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      if (if_acc != start) break;
    end
    check_eq("if_accept", {63'd0, if_acc != start}, 64'd1);
    if_req_valid = 1'b0;
  endtask

  task automatic ls_access(input logic [63:0] a, input logic w, input logic [63:0] d, input logic [7:0] m);
    int start;
    start = ls_acc;
    ls_addr = a; ls_wen = w; ls_wdata = d; ls_wmask = m;
    ls_req_valid = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      if (ls_acc != start) break;
    end
    check_eq("ls_accept", {63'd0, ls_acc != start}, 64'd1);
    ls_req_valid = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq(tag, {56'd0, busy, mem_req_valid, owner, mem_wen, if_resp_valid, ls_resp_valid,
                   if_req_ready, ls_req_ready}, 64'd0);
    check_eq({tag, "_bus"}, mem_addr | mem_wdata | {56'd0, mem_wmask} | if_rdata | ls_rdata
                            | {62'd0, if_resp_err, ls_resp_err}, 64'd0);
  endtask

  initial begin
    logic t3_exp [6];
    int base, s_if, s_ls;
    t3_exp = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    rst = 1'b0;
    if_req_valid = 1'b0; if_addr = 64'd0;
    ls_req_valid = 1'b0; ls_addr = 64'd0; ls_wen = 1'b0; ls_wdata = 64'd0; ls_wmask = 8'd0;
    #12;
    check_all_zero("reset_state");
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    // 1: lone IF read, zero-wait memory
    if_read(64'h0000_0000_8000_0000);
    wait_idle();

    // 2: simultaneous IF read and LS write; LS first, IF right at the LS response cycle
    base = grant_log.size();
    s_if = if_acc; s_ls = ls_acc;
    if_addr = 64'h0000_0000_8000_0040; if_req_valid = 1'b1;
    ls_addr = 64'h0000_0000_8000_1000; ls_wen = 1'b1;
    ls_wdata = 64'h0000_0000_DEAD_BEEF; ls_wmask = 8'h0F; ls_req_valid = 1'b1;
    for (int i = 0; i < 50 && (if_req_valid || ls_req_valid); i++) begin
      @(posedge clk); #1;
      if (ls_acc != s_ls) ls_req_valid = 1'b0;
      if (if_acc != s_if) if_req_valid = 1'b0;
    end
    wait_idle();
    check_eq("t2_grants", 64'(grant_log.size() - base), 64'd2);
    if (grant_log.size() - base >= 2) begin
      check_eq("t2_first_ls", {63'd0, grant_log[base]}, 64'd1);
      check_eq("t2_then_if", {63'd0, grant_log[base+1]}, 64'd0);
      check_eq("t2_if_gap", 64'(grant_cyc[base+1] - grant_cyc[base]), 64'd3);
    end

    // 3: both continuously valid, streak limit lets IF in after four LS grants
    base = grant_log.size();
    if_addr = 64'h0000_0000_8000_0080; if_req_valid = 1'b1;
    ls_addr = 64'h0000_0000_8000_2000; ls_wen = 1'b0; ls_wdata = 64'd0; ls_wmask = 8'd0;
    ls_req_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (grant_log.size() - base >= 6) break;
    end
    if_req_valid = 1'b0; ls_req_valid = 1'b0;
    wait_idle();
    check_eq("t3_grants", 64'(grant_log.size() - base), 64'd6);
    for (int i = 0; i < 6 && base + i < grant_log.size(); i++)
      check_eq("t3_order", {63'd0, grant_log[base+i]}, {63'd0, t3_exp[i]});

    // 4: downstream stalls the request for 5 cycles
    req_wait = 5;
    ls_access(64'h0000_0000_8000_3008, 1'b1, 64'h1122_3344_5566_7788, 8'hA5);
    wait_idle();
    req_wait = 0;

    // 5: no response at all, then a normal transaction
    no_resp = 1'b1;
    if_read(64'h0000_0000_8000_4000);
    wait_idle();
    no_resp = 1'b0;
    ls_access(64'h0000_0000_8000_5000, 1'b0, 64'd0, 8'd0);
    wait_idle();

    // 6: reset in RESP, then a stray response after release
    resp_wait = 10;
    ls_access(64'h0000_0000_8000_6000, 1'b0, 64'd0, 8'd0);
    repeat (3) @(posedge clk);
    #1;
    check_eq("t6_in_resp", {63'd0, busy & ~mem_req_valid}, 64'd1);
    rst = 1'b0;
    #1;
    check_all_zero("t6_async_reset");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    resp_wait = 0;
    stray_cyc = cyc + 2;
    repeat (5) @(posedge clk);
    #1;
    check_eq("t6_idle", {62'd0, busy, ls_resp_valid}, 64'd0);
    if_read(64'h0000_0000_8000_0000);
    wait_idle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

endmodule
